// File: rtl/core_regfile_pkg.sv
// Shared address-map offsets for the register file special locations.
// Offsets are relative to NUM_GP so one map serves every GP-count configuration.
package core_regfile_pkg;

  localparam int ADDR_PC_OFS   = 0;
  localparam int ADDR_ZERO_OFS = 1;
  localparam int ADDR_ONE_OFS  = 2;
  localparam int ADDR_ONES_OFS = 3;
  localparam int ADDR_BUS_OFS  = 4;
  localparam int NUM_SPECIAL   = 5;

  function automatic int mapAddr(input int numGp, input int ofs);
    return numGp + ofs;
  endfunction

endpackage

// File: rtl/core_regfile_read_mux.sv
// One combinational read port: address decode over GP/PC/constants/bus latch,
// with optional same-cycle forwarding of the write port for GP and PC addresses.
module core_regfile_read_mux
  import core_regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_GP = 11,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [NUM_GP-1:0][DATA_W-1:0]  gpRegs_i,
  input  logic [DATA_W-1:0]              pc_i,
  input  logic [DATA_W-1:0]              busReg_i,
  input  logic                           writeEnable_i,
  input  logic [ADDR_W-1:0]              addrWrite_i,
  input  logic [DATA_W-1:0]              dataWrite_i,
  output logic [DATA_W-1:0]              data_o
);

  localparam logic [ADDR_W-1:0] ADDR_PC   = ADDR_W'(mapAddr(NUM_GP, ADDR_PC_OFS));
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(mapAddr(NUM_GP, ADDR_ZERO_OFS));
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(mapAddr(NUM_GP, ADDR_ONE_OFS));
  localparam logic [ADDR_W-1:0] ADDR_ONES = ADDR_W'(mapAddr(NUM_GP, ADDR_ONES_OFS));
  localparam logic [ADDR_W-1:0] ADDR_BUS  = ADDR_W'(mapAddr(NUM_GP, ADDR_BUS_OFS));

  // Forwarding is limited to GP and PC; constants and the bus latch are never writable.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_GP; i++) begin
      if (addr_i == ADDR_W'(i)) data_o = gpRegs_i[i];
    end
    if (addr_i == ADDR_PC)        data_o = pc_i;
    else if (addr_i == ADDR_ZERO) data_o = '0;
    else if (addr_i == ADDR_ONE)  data_o = DATA_W'(1);
    else if (addr_i == ADDR_ONES) data_o = '1;
    else if (addr_i == ADDR_BUS)  data_o = busReg_i;
    if ((BYPASS != 0) && writeEnable_i && (addrWrite_i == addr_i) && (addrWrite_i <= ADDR_PC))
      data_o = dataWrite_i;
  end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-read-port register file: GP registers, PC with configurable step and
// reset vector, constant sources and a handshaked single-word bus input latch.
module core_regfile_mp
  import core_regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_GP   = 11,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int PC_STEP  = 1,
  parameter int PC_RESET = 0,
  parameter int DBG_IDX  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] addr_read,
  output logic [NUM_RD*DATA_W-1:0] data_read,
  input  logic [ADDR_W-1:0]        addr_write,
  input  logic [DATA_W-1:0]        data_write,
  input  logic                     write_enable,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc_out,
  input  logic [DATA_W-1:0]        bus_datain,
  input  logic                     bus_valid,
  output logic                     bus_ready,
  input  logic                     bus_pop,
  output logic                     bus_full,
  output logic [DATA_W-1:0]        dbg_reg_out
);

  localparam logic [ADDR_W-1:0] ADDR_PC = ADDR_W'(mapAddr(NUM_GP, ADDR_PC_OFS));

  if (NUM_GP + NUM_SPECIAL > 2**ADDR_W) begin : g_badAddrW
    $error("core_regfile_mp: NUM_GP+5 (%0d) exceeds 2**ADDR_W (%0d)", NUM_GP + NUM_SPECIAL, 2**ADDR_W);
  end
  if (DBG_IDX >= NUM_GP) begin : g_badDbgIdx
    $error("core_regfile_mp: DBG_IDX (%0d) must be below NUM_GP (%0d)", DBG_IDX, NUM_GP);
  end

  logic [NUM_GP-1:0][DATA_W-1:0] gp_q, gp_d;
  logic [DATA_W-1:0]             pc_q, pc_d;
  logic [DATA_W-1:0]             busReg_q, busReg_d;
  logic                          busFull_q, busFull_d;
  logic                          busXfer;

  assign bus_ready   = !busFull_q || bus_pop;
  assign busXfer     = bus_valid && bus_ready;
  assign pc_out      = pc_q;
  assign bus_full    = busFull_q;
  assign dbg_reg_out = gp_q[DBG_IDX];

  // An explicit PC write beats the increment; a new transfer beats a pop.
  always_comb begin
    gp_d = gp_q;
    for (int i = 0; i < NUM_GP; i++) begin
      if (write_enable && (addr_write == ADDR_W'(i))) gp_d[i] = data_write;
    end
    pc_d = pc_q;
    if (write_enable && (addr_write == ADDR_PC)) pc_d = data_write;
    else if (pc_inc)                             pc_d = pc_q + DATA_W'(PC_STEP);
    busReg_d  = busXfer ? bus_datain : busReg_q;
    busFull_d = busFull_q;
    if (busXfer)      busFull_d = 1'b1;
    else if (bus_pop) busFull_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gp_q      <= '0;
      pc_q      <= DATA_W'(PC_RESET);
      busReg_q  <= '0;
      busFull_q <= 1'b0;
    end else begin
      gp_q      <= gp_d;
      pc_q      <= pc_d;
      busReg_q  <= busReg_d;
      busFull_q <= busFull_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_readPort
    core_regfile_read_mux #(
      .DATA_W (DATA_W),
      .NUM_GP (NUM_GP),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_readMux (
      .addr_i        (addr_read[k*ADDR_W +: ADDR_W]),
      .gpRegs_i      (gp_q),
      .pc_i          (pc_q),
      .busReg_i      (busReg_q),
      .writeEnable_i (write_enable),
      .addrWrite_i   (addr_write),
      .dataWrite_i   (data_write),
      .data_o        (data_read[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Directed bench: default 16-bit/11-GP/bypass instance plus a 32-bit,
// 8-GP, 3-port, no-bypass instance with non-default PC step and reset vector.
module tb_core_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration instance
  logic [7:0]  addr_read;
  logic [31:0] data_read;
  logic [3:0]  addr_write;
  logic [15:0] data_write;
  logic        write_enable, pc_inc, bus_valid, bus_pop;
  logic [15:0] bus_datain;
  logic [15:0] pc_out, dbg_reg_out;
  logic        bus_ready, bus_full;

  core_regfile_mp dut (
    .clk(clk), .rst(rst), .addr_read(addr_read), .data_read(data_read),
    .addr_write(addr_write), .data_write(data_write), .write_enable(write_enable),
    .pc_inc(pc_inc), .pc_out(pc_out), .bus_datain(bus_datain), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_pop(bus_pop), .bus_full(bus_full), .dbg_reg_out(dbg_reg_out)
  );

  // Wide, three-port, no-bypass instance
  logic [11:0] addrRead2;
  logic [95:0] dataRead2;
  logic [3:0]  addrWrite2;
  logic [31:0] dataWrite2, busDatain2, pcOut2, dbgOut2;
  logic        writeEnable2, pcInc2, busValid2, busPop2, busReady2, busFull2;

  core_regfile_mp #(
    .DATA_W(32), .NUM_GP(8), .ADDR_W(4), .NUM_RD(3), .BYPASS(0),
    .PC_STEP(4), .PC_RESET(32'h100), .DBG_IDX(7)
  ) dut2 (
    .clk(clk), .rst(rst), .addr_read(addrRead2), .data_read(dataRead2),
    .addr_write(addrWrite2), .data_write(dataWrite2), .write_enable(writeEnable2),
    .pc_inc(pcInc2), .pc_out(pcOut2), .bus_datain(busDatain2), .bus_valid(busValid2),
    .bus_ready(busReady2), .bus_pop(busPop2), .bus_full(busFull2), .dbg_reg_out(dbgOut2)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  aw;
    logic [15:0] wd;
    logic        pcInc;
    logic        bv;
    logic [15:0] bd;
    logic        bp;
    logic [3:0]  ar0;
    logic [3:0]  ar1;
    logic [15:0] expDr0;
    logic [15:0] expDr1;
    logic        expReady;
    logic [15:0] expPc;
    logic        expFull;
    logic [15:0] expDbg;
  } vec_t;

  vec_t vecs[10];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    write_enable = 1'b0; addr_write = '0; data_write = '0; pc_inc = 1'b0;
    bus_valid = 1'b0; bus_datain = '0; bus_pop = 1'b0; addr_read = '0;
    writeEnable2 = 1'b0; addrWrite2 = '0; dataWrite2 = '0; pcInc2 = 1'b0;
    busValid2 = 1'b0; busDatain2 = '0; busPop2 = 1'b0; addrRead2 = '0;
  endtask

  // Drive one vector, check the combinational view, then the registered view after the edge.
  task automatic applyStimulus(input vec_t v);
    write_enable = v.we; addr_write = v.aw; data_write = v.wd; pc_inc = v.pcInc;
    bus_valid = v.bv; bus_datain = v.bd; bus_pop = v.bp;
    addr_read = {v.ar1, v.ar0};
    #1;
    checkOutput({v.name, ".dr0"},   {16'h0, data_read[15:0]},  {16'h0, v.expDr0});
    checkOutput({v.name, ".dr1"},   {16'h0, data_read[31:16]}, {16'h0, v.expDr1});
    checkOutput({v.name, ".ready"}, {31'h0, bus_ready},        {31'h0, v.expReady});
    @(posedge clk); #1;
    checkOutput({v.name, ".pc"},    {16'h0, pc_out},           {16'h0, v.expPc});
    checkOutput({v.name, ".full"},  {31'h0, bus_full},         {31'h0, v.expFull});
    checkOutput({v.name, ".dbg"},   {16'h0, dbg_reg_out},      {16'h0, v.expDbg});
  endtask

  initial begin
    //              name     we aw     wd        inc bv bd        bp ar0    ar1    dr0       dr1       rdy pc        full dbg
    vecs[0] = '{"bypassR3",  1, 4'd3,  16'h1234, 0,  0, 16'h0000, 0, 4'd3,  4'd3,  16'h1234, 16'h1234, 1,  16'h0000, 0,  16'h0000};
    vecs[1] = '{"readR3",    0, 4'd0,  16'h0000, 1,  0, 16'h0000, 0, 4'd3,  4'd12, 16'h1234, 16'h0000, 1,  16'h0001, 0,  16'h0000};
    vecs[2] = '{"consts",    1, 4'd7,  16'hCAFE, 1,  0, 16'h0000, 0, 4'd13, 4'd14, 16'h0001, 16'hFFFF, 1,  16'h0002, 0,  16'hCAFE};
    vecs[3] = '{"wrConst",   1, 4'd12, 16'hBEEF, 0,  1, 16'hA5A5, 0, 4'd12, 4'd15, 16'h0000, 16'h0000, 1,  16'h0002, 1,  16'hCAFE};
    vecs[4] = '{"busStall",  1, 4'd15, 16'hBEEF, 0,  1, 16'h5A5A, 0, 4'd15, 4'd12, 16'hA5A5, 16'h0000, 0,  16'h0002, 1,  16'hCAFE};
    vecs[5] = '{"popXfer",   0, 4'd0,  16'h0000, 0,  1, 16'h5A5A, 1, 4'd15, 4'd7,  16'hA5A5, 16'hCAFE, 1,  16'h0002, 1,  16'hCAFE};
    vecs[6] = '{"popPcWr",   1, 4'd11, 16'h0400, 1,  0, 16'h0000, 1, 4'd15, 4'd11, 16'h5A5A, 16'h0400, 1,  16'h0400, 0,  16'hCAFE};
    vecs[7] = '{"popEmpty",  1, 4'd11, 16'hFFFF, 0,  0, 16'h0000, 1, 4'd15, 4'd11, 16'h5A5A, 16'hFFFF, 1,  16'hFFFF, 0,  16'hCAFE};
    vecs[8] = '{"pcWrap",    0, 4'd0,  16'h0000, 1,  0, 16'h0000, 0, 4'd11, 4'd3,  16'hFFFF, 16'h1234, 1,  16'h0000, 0,  16'hCAFE};
    vecs[9] = '{"writeR0",   1, 4'd0,  16'h0042, 0,  0, 16'h0000, 0, 4'd0,  4'd10, 16'h0042, 16'h0000, 1,  16'h0000, 0,  16'hCAFE};

    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst.pc",     {16'h0, pc_out},      32'h0);
    checkOutput("rst.full",   {31'h0, bus_full},    32'h0);
    checkOutput("rst.ready",  {31'h0, bus_ready},   32'h1);
    checkOutput("rst.pc2",    pcOut2,               32'h100);
    checkOutput("rst.ready2", {31'h0, busReady2},   32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    idleInputs();

    // Reset while a write and a bus transfer are pending: both must be discarded.
    write_enable = 1'b1; addr_write = 4'd3; data_write = 16'h9999;
    bus_valid = 1'b1; bus_datain = 16'h1111; pc_inc = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idleInputs();
    #1;
    checkOutput("midRst.full",  {31'h0, bus_full},    32'h0);
    checkOutput("midRst.ready", {31'h0, bus_ready},   32'h1);
    checkOutput("midRst.pc",    {16'h0, pc_out},      32'h0);
    checkOutput("midRst.dbg",   {16'h0, dbg_reg_out}, 32'h0);
    for (int k = 0; k < 11; k++) begin
      addr_read = {4'd0, 4'(k)};
      #1;
      checkOutput($sformatf("midRst.gp%0d", k), {16'h0, data_read[15:0]}, 32'h0);
    end
    addr_read = {4'd13, 4'd12}; #1;
    checkOutput("midRst.a12", {16'h0, data_read[15:0]},  32'h0000);
    checkOutput("midRst.a13", {16'h0, data_read[31:16]}, 32'h0001);
    addr_read = {4'd15, 4'd14}; #1;
    checkOutput("midRst.a14", {16'h0, data_read[15:0]},  32'h0000FFFF);
    checkOutput("midRst.a15", {16'h0, data_read[31:16]}, 32'h0000);
    @(posedge clk); #1;

    // Wide instance: no bypass, PC at 8, bus at 12, PC step 4.
    writeEnable2 = 1'b1; addrWrite2 = 4'd2; dataWrite2 = 32'h12345678; pcInc2 = 1'b1;
    addrRead2 = {4'd8, 4'd5, 4'd2};
    #1;
    checkOutput("nb.oldR2", dataRead2[31:0], 32'h0);
    @(posedge clk); #1;
    checkOutput("nb.newR2", dataRead2[31:0], 32'h12345678);
    checkOutput("nb.pcStep", pcOut2, 32'h104);
    writeEnable2 = 1'b1; addrWrite2 = 4'd5; dataWrite2 = 32'hDEADBEEF; pcInc2 = 1'b0;
    #1;
    checkOutput("nb.oldR5", dataRead2[63:32], 32'h0);
    @(posedge clk); #1;
    addrWrite2 = 4'd8; dataWrite2 = 32'h400;
    #1;
    checkOutput("nb.oldPc", dataRead2[95:64], 32'h104);
    @(posedge clk); #1;
    writeEnable2 = 1'b0;
    #1;
    checkOutput("nb.port0", dataRead2[31:0],  32'h12345678);
    checkOutput("nb.port1", dataRead2[63:32], 32'hDEADBEEF);
    checkOutput("nb.port2", dataRead2[95:64], 32'h400);
    addrRead2 = {4'd11, 4'd10, 4'd9};
    busValid2 = 1'b1; busDatain2 = 32'hAABBCCDD;
    #1;
    checkOutput("nb.zero", dataRead2[31:0],  32'h0);
    checkOutput("nb.one",  dataRead2[63:32], 32'h1);
    checkOutput("nb.ones", dataRead2[95:64], 32'hFFFFFFFF);
    @(posedge clk); #1;
    busValid2 = 1'b0;
    addrRead2 = {4'd12, 4'd12, 4'd12};
    #1;
    checkOutput("nb.full", {31'h0, busFull2}, 32'h1);
    checkOutput("nb.bus",  dataRead2[95:64],  32'hAABBCCDD);
    idleInputs();
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
